// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared types for the scandoubler line-doubling stage
//
// Contents:
//   sd_state_e    - lock FSM states: IDLE, LOCK, RUN
//   sd_scanline_e - scanline darkening level encoding (2 bits)
//   sd_pixel_t    - packed {r,g,b} pixel at the default colour depth
package sd_pkg;

    localparam int SD_HCNT_W  = 10;
    localparam int SD_COLOR_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        RUN  = 2'd2
    } sd_state_e;

    typedef enum logic [1:0] {
        SL_OFF   = 2'd0,
        SL_DIM25 = 2'd1,
        SL_DIM50 = 2'd2,
        SL_DIM75 = 2'd3
    } sd_scanline_e;

    typedef struct packed {
        logic [SD_COLOR_W-1:0] r;
        logic [SD_COLOR_W-1:0] g;
        logic [SD_COLOR_W-1:0] b;
    } sd_pixel_t;

endpackage

// File: rtl/sd_line_ram.sv
// rtl/sd_line_ram.sv - dual-bank line buffer, one write port, one registered read port
//
// Ports:
//   clk_sys          - system clock
//   we, waddr, wdata - write port; waddr MSB selects the bank
//   re, raddr        - read port; raddr MSB selects the bank
//   rdata            - read data, registered when re is high
module sd_line_ram #(
    parameter int AW = 10,
    parameter int DW = 18
) (
    input  logic          clk_sys,
    input  logic          we,
    input  logic [AW:0]   waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW:0]   raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**(AW+1))-1];

    always_ff @(posedge clk_sys) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/scandoubler.sv
// rtl/scandoubler.sv - 15 kHz to 31 kHz line doubler with registered pass-through
//
// Optional feature macro: SD_SCANLINES_EN (darkens odd output lines by `scanlines`).
//
// Ports:
//   clk_sys, reset_n        - system clock, asynchronous active-low reset
//   ce_pix, ce_pix_x2       - input pixel enable and double-rate output enable
//   enable                  - 1 doubles, 0 passes the input through registered
//   scanlines               - darkening level for odd output lines
//   hs_in, vs_in, r/g/b_in  - core video in (active-high syncs)
//   hs_out, vs_out, r/g/b_out - doubled or passed-through video out
module scandoubler
    import sd_pkg::*;
#(
    parameter int HCNT_W  = SD_HCNT_W,
    parameter int COLOR_W = SD_COLOR_W
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ce_pix,
    input  logic               ce_pix_x2,
    input  logic               enable,
    input  logic [1:0]         scanlines,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic               hs_out,
    output logic               vs_out,
    output logic [COLOR_W-1:0] r_out,
    output logic [COLOR_W-1:0] g_out,
    output logic [COLOR_W-1:0] b_out
);

    localparam int PW = 3 * COLOR_W;
    localparam logic [HCNT_W-1:0] HMAX = '1;

    sd_state_e state, state_next;

    logic              hs_prev;
    logic              wbank;
    logic              vs_dly;
    logic              odd;
    logic [HCNT_W-1:0] hcnt_in;
    logic [HCNT_W-1:0] hcnt_out;
    logic [HCNT_W-1:0] line_len;
    logic [HCNT_W-1:0] hs_cnt;
    logic [HCNT_W-1:0] hs_len;
    logic              hs_rise;
    logic              hs_fall;

    logic              ram_we;
    logic [HCNT_W:0]   ram_waddr;
    logic [HCNT_W:0]   ram_raddr;
    logic [PW-1:0]     ram_rdata;
    logic [PW-1:0]     shaded;

    logic              hs_s1;
    logic              vs_s1;
    logic              odd_s1;
    logic              run_s1;

    // Sync edges are only meaningful on input pixel ticks.
    assign hs_rise = ce_pix & hs_in & ~hs_prev;
    assign hs_fall = ce_pix & ~hs_in & hs_prev;

    // ---------------- lock FSM ----------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else if (hs_rise) begin
            case (state)
                IDLE:    state_next = LOCK;
                LOCK:    state_next = RUN;
                default: state_next = state;
            endcase
        end
    end

    // ---------------- input side ----------------
    // The pixel arriving with the hs_in rising edge is pixel 0 of the new
    // line: it lands at address 0 of the freshly selected bank, so the
    // counter restarts at 1 rather than 0.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hs_prev  <= 1'b0;
            wbank    <= 1'b0;
            vs_dly   <= 1'b0;
            hcnt_in  <= '0;
            line_len <= '0;
            hs_cnt   <= '0;
            hs_len   <= '0;
        end else if (ce_pix) begin
            hs_prev <= hs_in;
            if (hs_rise) begin
                line_len <= hcnt_in;
                hcnt_in  <= HCNT_W'(1);
                wbank    <= ~wbank;
                vs_dly   <= vs_in;
            end else if (hcnt_in != HMAX) begin
                hcnt_in <= hcnt_in + 1'b1;
            end

            if (hs_rise) begin
                hs_cnt <= HCNT_W'(1);
            end else if (hs_in && hs_cnt != HMAX) begin
                hs_cnt <= hs_cnt + 1'b1;
            end
            if (hs_fall) begin
                hs_len <= hs_cnt;
            end
        end
    end

    // Writes at the saturated address are dropped so an overlong line can
    // never spill past its bank.
    assign ram_we    = ce_pix & (hs_rise | (hcnt_in != HMAX));
    assign ram_waddr = hs_rise ? {~wbank, {HCNT_W{1'b0}}} : {wbank, hcnt_in};
    assign ram_raddr = {~wbank, hcnt_out};

    // ---------------- output side ----------------
    // hs_rise realignment takes priority over the normal wrap.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_out <= '0;
            odd      <= 1'b0;
        end else if (hs_rise) begin
            hcnt_out <= '0;
            odd      <= 1'b0;
        end else if (ce_pix_x2) begin
            if (hcnt_out == line_len - 1'b1) begin
                hcnt_out <= '0;
                odd      <= ~odd;
            end else begin
                hcnt_out <= hcnt_out + 1'b1;
            end
        end
    end

    sd_line_ram #(
        .AW (HCNT_W),
        .DW (PW)
    ) u_line_ram (
        .clk_sys (clk_sys),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   ({r_in, g_in, b_in}),
        .re      (ce_pix_x2),
        .raddr   (ram_raddr),
        .rdata   (ram_rdata)
    );

    // Sync/line attributes ride alongside the RAM read so they stay aligned
    // with colour through the output register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hs_s1  <= 1'b0;
            vs_s1  <= 1'b0;
            odd_s1 <= 1'b0;
            run_s1 <= 1'b0;
        end else if (ce_pix_x2) begin
            hs_s1  <= (hcnt_out < hs_len);
            vs_s1  <= vs_dly;
            odd_s1 <= odd;
            run_s1 <= (state == RUN);
        end
    end

`ifdef SD_SCANLINES_EN
    function automatic logic [COLOR_W-1:0] darken(input logic [COLOR_W-1:0] x,
                                                  input logic [1:0]         lvl);
        logic [COLOR_W-1:0] y;
        case (sd_scanline_e'(lvl))
            SL_DIM25: y = x - (x >> 2);
            SL_DIM50: y = x >> 1;
            SL_DIM75: y = x >> 2;
            default:  y = x;
        endcase
        return y;
    endfunction

    always_comb begin
        shaded = ram_rdata;
        if (odd_s1) begin
            shaded = {darken(ram_rdata[PW-1 -: COLOR_W], scanlines),
                      darken(ram_rdata[2*COLOR_W-1 -: COLOR_W], scanlines),
                      darken(ram_rdata[COLOR_W-1:0], scanlines)};
        end
    end
`else
    logic unused_scanline_inputs;
    assign unused_scanline_inputs = ^{scanlines, odd_s1};

    always_comb begin
        shaded = ram_rdata;
    end
`endif

    // ---------------- output register ----------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
        end else if (!enable) begin
            if (ce_pix) begin
                hs_out <= hs_in;
                vs_out <= vs_in;
                r_out  <= r_in;
                g_out  <= g_in;
                b_out  <= b_in;
            end
        end else if (ce_pix_x2) begin
            if (run_s1) begin
                hs_out <= hs_s1;
                vs_out <= vs_s1;
                {r_out, g_out, b_out} <= shaded;
            end else begin
                hs_out <= 1'b0;
                vs_out <= 1'b0;
                r_out  <= '0;
                g_out  <= '0;
                b_out  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_scandoubler.sv
// tb/tb_scandoubler.sv - randomized self-checking bench for scandoubler
module tb_scandoubler;

    localparam int CW  = 6;
    localparam int PRE = 5;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          ce_pix = 1'b0;
    logic          ce_pix_x2 = 1'b0;
    logic          enable = 1'b1;
    logic [1:0]    scanlines = 2'd0;
    logic          hs_in = 1'b0;
    logic          vs_in = 1'b0;
    logic [CW-1:0] r_in = '0;
    logic [CW-1:0] g_in = '0;
    logic [CW-1:0] b_in = '0;
    logic          hs_out, vs_out;
    logic [CW-1:0] r_out, g_out, b_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [19:0] obs [$];
    logic [17:0] lpix [0:5][0:1099];
    logic        lvs  [0:5];

    always #5 clk_sys = ~clk_sys;

    scandoubler #(.HCNT_W(10), .COLOR_W(CW)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ce_pix    (ce_pix),
        .ce_pix_x2 (ce_pix_x2),
        .enable    (enable),
        .scanlines (scanlines),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .r_in      (r_in),
        .g_in      (g_in),
        .b_in      (b_in),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out)
    );

    function automatic logic [19:0] outs();
        return {hs_out, vs_out, r_out, g_out, b_out};
    endfunction

    // Darkening written from the level table with plain arithmetic.
    function automatic logic [5:0] dk(input logic [5:0] x, input logic [1:0] lvl);
        int v;
        v = int'(x);
        case (lvl)
            2'd1:    v = v - v / 4;
            2'd2:    v = v / 2;
            2'd3:    v = v / 4;
            default: v = v;
        endcase
        return 6'(v);
    endfunction

    // One input pixel = 4 clk_sys cycles: two ce_pix_x2 ticks, the first
    // also a ce_pix tick. Outputs are logged 1 time unit after each x2 edge.
    task automatic pix(input logic hs, input logic vs, input logic [17:0] c);
        hs_in = hs;
        vs_in = vs;
        {r_in, g_in, b_in} = c;
        ce_pix = 1'b1;
        ce_pix_x2 = 1'b1;
        @(posedge clk_sys); #1;
        obs.push_back(outs());
        ce_pix = 1'b0;
        ce_pix_x2 = 1'b0;
        @(posedge clk_sys); #1;
        ce_pix_x2 = 1'b1;
        @(posedge clk_sys); #1;
        obs.push_back(outs());
        ce_pix_x2 = 1'b0;
        @(posedge clk_sys); #1;
    endtask

    task automatic do_reset();
        ce_pix = 1'b0;
        ce_pix_x2 = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk_sys);
        #2 reset_n = 1'b1;
        @(posedge clk_sys); #1;
    endtask

    // Drives PRE idle pixels then nl lines of w pixels (hs high for hsw
    // pixels at line start) and checks every logged output tick against
    // the model: during input line n the previous line n-1 is replayed
    // with period min(w,1023), 2 ticks late, with vs taken at line n start.
    task automatic run_and_check(input string name, input bit rst_first, input int nl,
                                 input int w, input int hsw, input bit pat,
                                 input logic [1:0] sl);
        int L, t, k, errs, bad_j;
        logic [19:0] exp_v, got_v, bad_exp, bad_got;
        logic [17:0] col;
        if (rst_first) do_reset();
        enable = 1'b1;
        scanlines = sl;
        obs.delete();
        for (int i = 0; i < PRE; i++) pix(1'b0, 1'b0, 18'($urandom));
        for (int ln = 0; ln < nl; ln++) begin
            lvs[ln] = pat ? 1'b0 : 1'($urandom_range(0, 1));
            for (int p = 0; p < w; p++) begin
                col = pat ? {6'(ln), 6'd0, 6'd63} : 18'($urandom);
                lpix[ln][p] = col;
                pix(p < hsw, lvs[ln], col);
            end
        end
        L = (w > 1023) ? 1023 : w;

        errs = 0;
        bad_got = '0;
        for (int i = 0; i < 2 * PRE + 2 * w + 2; i++) begin
            if (obs[i] !== 20'd0) begin
                if (errs == 0) bad_got = obs[i];
                errs++;
            end
        end
        n_checks++;
        if (errs != 0)
            $display("FAIL %s idle_zero: %0d nonzero ticks before lock, first got %h required 0",
                     name, errs, bad_got);
        else
            n_pass++;

        for (int n = 1; n < nl; n++) begin
            errs = 0;
            bad_j = 0;
            bad_exp = '0;
            bad_got = '0;
            for (int j = 0; j < 2 * w; j++) begin
                t = 2 * w * n + 2 + j;
                if (2 * PRE + t >= obs.size()) break;
                k = j % L;
                col = lpix[n-1][k];
`ifdef SD_SCANLINES_EN
                if (((j / L) % 2) == 1)
                    col = {dk(col[17:12], sl), dk(col[11:6], sl), dk(col[5:0], sl)};
`endif
                exp_v = {1'(k < hsw), lvs[n], col};
                got_v = obs[2 * PRE + t];
                if (got_v !== exp_v) begin
                    if (errs == 0) begin
                        bad_j = j;
                        bad_exp = exp_v;
                        bad_got = got_v;
                    end
                    errs++;
                end
            end
            n_checks++;
            if (errs != 0)
                $display("FAIL %s line%0d: %0d bad ticks, first at tick %0d got %h required %h",
                         name, n, errs, bad_j, bad_got, bad_exp);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset();
        int errs;
        reset_n = 1'b0;
        enable = 1'b0;
        obs.delete();
        for (int i = 0; i < 6; i++) pix(i[0], 1'b1, 18'h3ffff);
        errs = 0;
        foreach (obs[i]) if (obs[i] !== 20'd0) errs++;
        n_checks++;
        if (errs != 0) $display("FAIL reset_outputs: %0d nonzero ticks, required 0", errs);
        else n_pass++;
        enable = 1'b1;
        reset_n = 1'b1;
        @(posedge clk_sys); #1;
        obs.delete();
        for (int i = 0; i < 6; i++) pix(i[1], 1'b1, 18'h2aaaa);
        errs = 0;
        foreach (obs[i]) if (obs[i] !== 20'd0) errs++;
        n_checks++;
        if (errs != 0) $display("FAIL idle_outputs: %0d nonzero ticks, required 0", errs);
        else n_pass++;
    endtask

    task automatic test_lockup();
        run_and_check("lockup", 1'b1, 6, 320, 24, 1'b1, 2'd0);
    endtask

    task automatic test_doubling();
        int w;
        for (int r = 0; r < 3; r++) begin
            w = $urandom_range(16, 200);
            run_and_check("doubling", 1'b1, 5, w, $urandom_range(1, w / 4), 1'b0,
                          2'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_overlength();
        run_and_check("overlength", 1'b1, 4, 1100, 40, 1'b0, 2'd0);
    endtask

    task automatic test_passthrough();
        logic [19:0] drv;
        do_reset();
        enable = 1'b0;
        obs.delete();
        for (int i = 0; i < 40; i++) begin
            drv = 20'($urandom);
            if (i == 0) drv[17:12] = 6'd42;
            pix(drv[19], drv[18], drv[17:0]);
            n_checks++;
            if (obs[2*i] !== drv || obs[2*i+1] !== drv)
                $display("FAIL passthrough px%0d: got %h/%h required %h",
                         i, obs[2*i], obs[2*i+1], drv);
            else
                n_pass++;
        end
        enable = 1'b1;
        obs.delete();
        pix(1'b1, 1'b1, 18'h3ffff);
        n_checks++;
        if (obs[0] !== 20'd0) $display("FAIL enable_on_restart: got %h required 0", obs[0]);
        else n_pass++;
        enable = 1'b0;
        obs.delete();
        pix(1'b0, 1'b1, 18'h15555);
        n_checks++;
        if (obs[0] !== {2'b01, 18'h15555})
            $display("FAIL enable_off_next_pix: got %h required %h", obs[0], {2'b01, 18'h15555});
        else
            n_pass++;
        enable = 1'b1;
    endtask

    task automatic test_scanlines();
        for (int s = 0; s < 4; s++)
            run_and_check("scanlines", 1'b1, 4, 48, 6, 1'b0, 2'(s));
    endtask

    task automatic test_midframe_reset();
        run_and_check("pre_reset", 1'b1, 3, 100, 8, 1'b1, 2'd0);
        n_checks++;
        if (b_out !== 6'd63) $display("FAIL running_before_reset: b_out got %0d required 63", b_out);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (outs() !== 20'd0) $display("FAIL async_reset: got %h required 0", outs());
        else n_pass++;
        #1 reset_n = 1'b1;
        @(posedge clk_sys); #1;
        run_and_check("relock", 1'b0, 4, 80, 6, 1'b0, 2'($urandom_range(0, 3)));
    endtask

    initial begin
        test_reset();
        test_lockup();
        test_doubling();
        test_overlength();
        test_passthrough();
        test_scanlines();
        test_midframe_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
